imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of both request ports and mem_addr.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive denied debug-request cycles before debug is boosted (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port f_req, input, 1, fetch-stage read request, held until granted.
REQ-006 SHALL have port f_addr, input, ADDR_W, fetch byte address, stable while f_req=1.
REQ-007 SHALL have port f_flush, input, 1, kills the fetch response of the grant in the same cycle (branch redirect).
REQ-008 SHALL have ports f_gnt (output, 1), f_rvalid (output, 1) and f_rdata (output, 32): fetch grant, response valid and response word.
REQ-009 SHALL have ports d_req (input, 1), d_addr (input, ADDR_W), d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, 32): debug/loader read port, same meaning as the fetch port.
REQ-010 SHALL have ports f_err and d_err, output, 1 each, misaligned-address error pulses.
REQ-011 SHALL have port mem_addr, output, ADDR_W, byte address driven to the asynchronous-read instruction memory.
REQ-012 SHALL have port mem_data, input, 32, combinational read data returned for mem_addr.

Function
REQ-013 SHALL grant at most one requester per cycle; f_gnt and d_gnt are combinational from req, state and counter.
REQ-014 In state PRI_F, SHALL grant fetch if f_req=1, otherwise debug if d_req=1.
REQ-015 In state PRI_D, SHALL grant debug if d_req=1, otherwise fetch if f_req=1.
REQ-016 SHALL drive mem_addr with the granted requester's address; with no grant, mem_addr SHALL equal f_addr.
REQ-017 SHALL capture mem_data into the granted port's rdata register at the grant edge; rvalid SHALL pulse high for exactly one cycle, on the cycle after the grant (latency 1).
REQ-018 rdata SHALL hold its last value while rvalid=0.
REQ-019 SHALL keep a saturating starve counter: increment when d_req=1 and d_gnt=0; clear when d_gnt=1 or d_req=0.
REQ-020 SHALL move PRI_F -> PRI_D on the edge at which the counter reaches STARVE_LIMIT, and PRI_D -> PRI_F on the edge of a debug grant.
REQ-021 f_flush=1 in a fetch-grant cycle SHALL suppress the following f_rvalid; f_rdata is still updated; f_flush has no effect in non-grant cycles.
REQ-022 Simultaneous f_req and d_req with counter below limit in PRI_F SHALL grant fetch only; back-to-back grants every cycle SHALL be sustained.

Reset
REQ-023 On rst=1 at a clock edge: state=PRI_F, starve counter=0, f_rvalid=d_rvalid=0, f_err=d_err=0, f_rdata=d_rdata=32'h0000_0013 (NOP).
REQ-024 While rst=1, f_gnt and d_gnt SHALL be 0; a grant in the cycle before reset asserts SHALL produce no rvalid.

Configuration
REQ-025 With macro IMEM_ARB_ALIGN_CHECK_EN defined, a granted request with addr[1:0]!=0 SHALL complete normally in timing, but return rdata=32'h0000_0013 and pulse the port's err with its rvalid (flush suppresses both).
REQ-026 Without IMEM_ARB_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored, f_err and d_err SHALL be tied 0, and no check logic SHALL be present.

Verification
REQ-027 Memory preloaded mem[3]=32'hDEADBEEF; f_req with f_addr=0x0C -> f_gnt same cycle, f_rvalid=1 and f_rdata=32'hDEADBEEF next cycle.
REQ-028 f_req and d_req held continuously, STARVE_LIMIT=4 -> 4 fetch grants, then d_gnt on the 5th cycle, then fetch grants resume.
REQ-029 Fetch grant at 0x10 with f_flush=1 -> f_rvalid stays 0 next cycle; an unflushed fetch the following cycle returns f_rvalid=1.
REQ-030 d_req alone at d_addr=0x04 -> d_gnt immediately, d_rvalid=1 next cycle with mem[1], counter remains 0.
REQ-031 rst asserted in the cycle after a grant -> f_rvalid=0, f_rdata=32'h00000013, and state returns to PRI_F.
REQ-032 With IMEM_ARB_ALIGN_CHECK_EN, f_addr=0x0E -> f_rvalid=1, f_err=1, f_rdata=32'h00000013; without the macro -> f_err=0 and f_rdata=mem[3].

Source files
------------

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//   Two-port read arbiter in front of an asynchronous-read instruction memory.
//   The fetch port normally has priority. A debug/loader port that keeps being
//   denied is boosted to priority after STARVE_LIMIT consecutive denied cycles
//   and holds that priority until it is granted once. Read data returns with a
//   fixed latency of one cycle.
//
//   Optional feature (macro IMEM_ARB_ALIGN_CHECK_EN): a granted request whose
//   byte address is not word aligned completes with the usual timing. It
//   returns a NOP word and pulses the port's err output together with rvalid.
//   Without the macro the low address bits are ignored and err is tied to 0.
//
// Parameters
//   ADDR_W        byte-address width of f_addr, d_addr and mem_addr
//   STARVE_LIMIT  denied debug cycles before debug is boosted (1..15)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   f_req, f_addr, f_flush     fetch request, byte address, kill of this grant
//   f_gnt, f_rvalid, f_rdata   fetch grant (comb), response valid, response word
//   f_err                      fetch misaligned-address pulse
//   d_req, d_addr              debug request, byte address
//   d_gnt, d_rvalid, d_rdata   debug grant (comb), response valid, response word
//   d_err                      debug misaligned-address pulse
//   mem_addr, mem_data         memory byte address out, combinational data in
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {PRI_F, PRI_D} pri_e;

  pri_e       state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       f_rv_q, d_rv_q;
  logic [31:0] rdata_in;

  // Grant, starve counter and priority next-state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    state_d  = state_q;
    starve_d = '0;

    if (!rst) begin
      if (state_q == PRI_F) begin
        f_gnt = f_req;
        d_gnt = d_req && !f_req;
      end else begin
        d_gnt = d_req;
        f_gnt = f_req && !d_req;
      end
    end

    if (d_req && !d_gnt)
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;

    case (state_q)
      PRI_F: if (starve_d == LIMIT) state_d = PRI_D;
      PRI_D: if (d_gnt)             state_d = PRI_F;
      default: state_d = PRI_F;
    endcase
  end

  assign mem_addr = d_gnt ? d_addr : f_addr;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  logic misaligned;
  logic f_err_q, d_err_q;

  assign misaligned = (mem_addr[1:0] != 2'b00);
  assign rdata_in   = misaligned ? NOP : mem_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      f_err_q <= f_gnt && !f_flush && misaligned;
      d_err_q <= d_gnt && misaligned;
    end
  end

  assign f_err = f_err_q && !rst;
  assign d_err = d_err_q && !rst;
`else
  assign rdata_in = mem_data;
  assign f_err    = 1'b0;
  assign d_err    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PRI_F;
      starve_q <= '0;
      f_rv_q   <= 1'b0;
      d_rv_q   <= 1'b0;
      f_rdata  <= NOP;
      d_rdata  <= NOP;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      // A flushed fetch still refreshes f_rdata; only the valid is dropped.
      f_rv_q   <= f_gnt && !f_flush;
      d_rv_q   <= d_gnt;
      if (f_gnt) f_rdata <= rdata_in;
      if (d_gnt) d_rdata <= rdata_in;
    end
  end

  // NOTE: rvalid is masked by rst so a response from the grant just before
  // reset is never presented while reset is being applied.
  assign f_rvalid = f_rv_q && !rst;
  assign d_rvalid = d_rv_q && !rst;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//   Directed bench for imem_arbiter with a small memory model. The driver
//   checks grants and mem_addr in the grant cycle and pushes the expected
//   response into a per-port queue; a monitor pops and compares whenever a
//   port presents rvalid. Define IMEM_ARB_ALIGN_CHECK_EN for both files to
//   exercise the alignment-check build.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int ADDR_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req, f_flush, d_req;
  logic [ADDR_W-1:0] f_addr, d_addr, mem_addr;
  logic              f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
  logic [31:0]       f_rdata, d_rdata, mem_data;

  logic [31:0] mem [0:63];
  exp_t        fq[$];
  exp_t        dq[$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr[7:2]];

  imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t expect_for(input logic [31:0] addr);
    exp_t e;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    e.err  = (addr[1:0] != 2'b00);
    e.data = e.err ? NOP : mem[addr[7:2]];
`else
    e.err  = 1'b0;
    e.data = mem[addr[7:2]];
`endif
    return e;
  endfunction

  // One cycle of stimulus: drive just after the rising edge, check the
  // combinational grant and address, and queue the expected responses.
  task automatic step(input logic rs, input logic fr, input logic [31:0] fa,
                      input logic ff, input logic dr, input logic [31:0] da,
                      input logic efg, input logic edg, input string tag);
    @(posedge clk);
    #1;
    rst = rs; f_req = fr; f_addr = fa; f_flush = ff; d_req = dr; d_addr = da;
    #2;
    check({tag, "_f_gnt"}, 32'(f_gnt), 32'(efg));
    check({tag, "_d_gnt"}, 32'(d_gnt), 32'(edg));
    check({tag, "_mem_addr"}, mem_addr, edg ? da : fa);
    if (efg && !ff && !rs) fq.push_back(expect_for(fa));
    if (edg && !rs)        dq.push_back(expect_for(da));
  endtask

  // Monitor: compare every presented response against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (f_rvalid) begin
        if (fq.size() == 0) begin
          checks++; failures++;
          $display("FAIL f_unexpected_rvalid actual=1 expected=0 data=%h", f_rdata);
        end else begin
          e = fq.pop_front();
          check("f_rdata", f_rdata, e.data);
          check("f_err", 32'(f_err), 32'(e.err));
        end
      end else if (f_err) begin
        checks++; failures++;
        $display("FAIL f_err_without_rvalid actual=1 expected=0");
      end
      if (d_rvalid) begin
        if (dq.size() == 0) begin
          checks++; failures++;
          $display("FAIL d_unexpected_rvalid actual=1 expected=0 data=%h", d_rdata);
        end else begin
          e = dq.pop_front();
          check("d_rdata", d_rdata, e.data);
          check("d_err", 32'(d_err), 32'(e.err));
        end
      end else if (d_err) begin
        checks++; failures++;
        $display("FAIL d_err_without_rvalid actual=1 expected=0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t dropped;
    for (int i = 0; i < 64; i++) mem[i] = {16'hC0DE, 8'h00, 8'(i)};
    mem[3] = 32'hDEAD_BEEF;
    rst = 1'b1; f_req = 1'b0; f_addr = '0; f_flush = 1'b0;
    d_req = 1'b0; d_addr = '0;

    // Reset: no grants while rst is high even with both requesting.
    step(1, 1, 32'h0C, 0, 1, 32'h04, 0, 0, "rst0");
    step(1, 1, 32'h0C, 0, 1, 32'h04, 0, 0, "rst1");

    // Fetch of mem[3]; the previous edge was a reset edge.
    step(0, 1, 32'h0C, 0, 0, 32'h00, 1, 0, "fetch_0c");
    check("rst_f_rdata", f_rdata, NOP);
    check("rst_d_rdata", d_rdata, NOP);
    check("rst_f_rvalid", 32'(f_rvalid), 32'd0);

    // No grant: mem_addr follows f_addr.
    step(0, 0, 32'h20, 0, 0, 32'h00, 0, 0, "idle");
    // Debug alone is granted at once.
    step(0, 0, 32'h20, 0, 1, 32'h04, 0, 1, "dbg_04");

    // Contention: four fetch grants, debug on the fifth, fetch resumes.
    step(0, 1, 32'h00, 0, 1, 32'h18, 1, 0, "starve1");
    step(0, 1, 32'h04, 0, 1, 32'h18, 1, 0, "starve2");
    step(0, 1, 32'h08, 0, 1, 32'h18, 1, 0, "starve3");
    step(0, 1, 32'h14, 0, 1, 32'h18, 1, 0, "starve4");
    step(0, 1, 32'h1C, 0, 1, 32'h18, 0, 1, "boost");
    step(0, 1, 32'h1C, 0, 0, 32'h00, 1, 0, "resume");

    // Boost again, then PRI_D falls back to fetch when debug is idle and
    // keeps debug priority until debug is granted.
    step(0, 1, 32'h20, 0, 1, 32'h30, 1, 0, "s2_1");
    step(0, 1, 32'h24, 0, 1, 32'h30, 1, 0, "s2_2");
    step(0, 1, 32'h28, 0, 1, 32'h30, 1, 0, "s2_3");
    step(0, 1, 32'h2C, 0, 1, 32'h30, 1, 0, "s2_4");
    step(0, 1, 32'h30, 0, 0, 32'h00, 1, 0, "prid_fallback");
    step(0, 1, 32'h34, 0, 1, 32'h38, 0, 1, "prid_dbg");

    // Flushed fetch: no valid, but f_rdata still captures mem[4].
    step(0, 1, 32'h10, 1, 0, 32'h00, 1, 0, "flush");
    step(0, 1, 32'h08, 0, 0, 32'h00, 1, 0, "after_flush");
    check("flush_f_rvalid", 32'(f_rvalid), 32'd0);
    check("flush_f_rdata", f_rdata, mem[4]);

    // Flush without a fetch grant does not disturb debug.
    step(0, 0, 32'h08, 1, 1, 32'h3C, 0, 1, "flush_nogrant");

    // Misaligned fetch and debug addresses.
    step(0, 1, 32'h0E, 0, 0, 32'h00, 1, 0, "mis_f");
    step(0, 0, 32'h0E, 0, 1, 32'h0D, 0, 1, "mis_d");

    // Reach PRI_D, grant fetch, then reset in the following cycle.
    step(0, 1, 32'h00, 0, 1, 32'h20, 1, 0, "s3_1");
    step(0, 1, 32'h04, 0, 1, 32'h20, 1, 0, "s3_2");
    step(0, 1, 32'h08, 0, 1, 32'h20, 1, 0, "s3_3");
    step(0, 1, 32'h0C, 0, 1, 32'h20, 1, 0, "s3_4");
    step(0, 1, 32'h14, 0, 0, 32'h00, 1, 0, "pre_rst");
    // Reset cancels the response of the pre_rst grant.
    dropped = fq.pop_back();
    step(1, 0, 32'h14, 0, 0, 32'h00, 0, 0, "in_rst");
    check("in_rst_f_rvalid", 32'(f_rvalid), 32'd0);
    // Priority returned to fetch after reset.
    step(0, 1, 32'h04, 0, 1, 32'h08, 1, 0, "post_rst");
    check("post_rst_f_rdata", f_rdata, NOP);
    step(0, 0, 32'h00, 0, 0, 32'h00, 0, 0, "tail");

    repeat (3) @(posedge clk);
    check("f_queue_drained", 32'(fq.size()), 32'd0);
    check("d_queue_drained", 32'(dq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
